// File: rtl/acq_pkg.sv
// Shared encodings for the acquisition sequencer: FSM states, control bit, trigger modes.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } acq_state_e;

  localparam int unsigned CTRL_RESET_BIT = 0;
  localparam int unsigned TIMEBASE_W     = 32;
  localparam int unsigned SAMPLE_W       = 8;

  localparam logic TRIG_EDGE_RISING  = 1'b0;
  localparam logic TRIG_EDGE_FALLING = 1'b1;
  localparam logic TRIG_MODE_AUTO    = 1'b0;
  localparam logic TRIG_MODE_NORMAL  = 1'b1;

  // Status byte returned on the status read: {done, 4'b0, state}
  function automatic logic [7:0] status_byte(input logic done, input acq_state_e st);
    return {done, 4'b0000, st};
  endfunction

endpackage

// File: rtl/acquisition_sequencer_if.sv
// Configuration/control from the command decoder and the sample-RAM write port.
interface acquisition_sequencer_if #(
  parameter int unsigned ADDR_W = 11
);
  logic [31:0]       i_timebase;
  logic              i_trig_edge;
  logic [7:0]        i_trig_level;
  logic              i_trig_mode;
  logic              i_trig_enable;
  logic              i_ctrl_wr;
  logic [7:0]        i_ctrl_data;
  logic [7:0]        i_adc1A;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [ADDR_W-1:0] o_trig_addr;
  logic              o_done;
  logic [7:0]        o_status;

  modport master (
    output i_timebase, i_trig_edge, i_trig_level, i_trig_mode, i_trig_enable,
    output i_ctrl_wr, i_ctrl_data, i_adc1A,
    input  o_we, o_addr, o_trig_addr, o_done, o_status
  );

  modport slave (
    input  i_timebase, i_trig_edge, i_trig_level, i_trig_mode, i_trig_enable,
    input  i_ctrl_wr, i_ctrl_data, i_adc1A,
    output o_we, o_addr, o_trig_addr, o_done, o_status
  );
endinterface

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one tick every i_timebase+1 enabled clocks.
module sample_tick_gen
  import acq_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [TIMEBASE_W-1:0] i_timebase,
  output logic                  o_tick_c
);

  logic [TIMEBASE_W-1:0] cnt_q, cnt_d;

  assign o_tick_c = i_en && (cnt_q == i_timebase);

  // Counter restarts on tick, when idle, or on a control reset
  always_comb begin
    cnt_d = cnt_q + TIMEBASE_W'(1);
    if (i_clr || !i_en || o_tick_c) cnt_d = '0;
  end

  // Divider register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/acquisition_sequencer.sv
// One ADC capture: pre-trigger fill, trigger search on 1A, post-trigger fill, done.
module acquisition_sequencer
  import acq_pkg::*;
#(
  parameter int unsigned DEPTH       = 1500,
  parameter int unsigned PRE_SAMPLES = 750,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned AUTO_TICKS  = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  acquisition_sequencer_if.slave bus
);

  localparam int unsigned POST_SAMPLES = DEPTH - PRE_SAMPLES - 1;
  localparam int unsigned CNT_MAX      = (DEPTH > AUTO_TICKS) ? DEPTH : AUTO_TICKS;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);

  acq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, addr_q, addr_d, trig_addr_q, trig_addr_d;
  logic [7:0]        prev_q, prev_d, status_q, status_d;
  logic              we_q, we_d, done_q, done_d;
  logic              run_c, tick_c, tick_ok_c, ctrl_rst_c, ctrl_start_c;
  logic              rise_c, fall_c, edge_hit_c, auto_hit_c, trig_c;
  logic              unused_ctrl_c;

  assign run_c         = (state_q == ST_PREFILL) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign ctrl_rst_c    = bus.i_ctrl_wr && bus.i_ctrl_data[CTRL_RESET_BIT];
  assign ctrl_start_c  = bus.i_ctrl_wr && !bus.i_ctrl_data[CTRL_RESET_BIT] &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign tick_ok_c     = tick_c && !bus.i_ctrl_wr;
  assign unused_ctrl_c = ^bus.i_ctrl_data;

  sample_tick_gen u_tick (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (run_c),
    .i_clr      (ctrl_rst_c),
    .i_timebase (bus.i_timebase),
    .o_tick_c   (tick_c)
  );

  // Trigger comparator; the first ARMED tick has no valid previous sample
  always_comb begin
    rise_c     = (prev_q < bus.i_trig_level) && (bus.i_adc1A >= bus.i_trig_level);
    fall_c     = (prev_q > bus.i_trig_level) && (bus.i_adc1A <= bus.i_trig_level);
    edge_hit_c = (cnt_q != '0) &&
                 ((bus.i_trig_edge == TRIG_EDGE_FALLING) ? fall_c : rise_c);
    auto_hit_c = (bus.i_trig_mode == TRIG_MODE_AUTO) && (cnt_q == CNT_W'(AUTO_TICKS - 1));
    trig_c     = !bus.i_trig_enable || auto_hit_c || edge_hit_c;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; control writes take priority over ticks
  always_comb begin
    state_d = state_q;
    if (ctrl_rst_c) begin
      state_d = ST_IDLE;
    end else if (ctrl_start_c) begin
      state_d = ST_PREFILL;
    end else if (tick_ok_c) begin
      case (state_q)
        ST_PREFILL: if (cnt_q == CNT_W'(PRE_SAMPLES - 1)) state_d = ST_ARMED;
        ST_ARMED:   if (trig_c) state_d = (POST_SAMPLES == 0) ? ST_DONE : ST_POST;
        ST_POST:    if (cnt_q == CNT_W'(POST_SAMPLES - 1)) state_d = ST_DONE;
        default:    state_d = state_q;
      endcase
    end
  end

  // Output and datapath next values: write pacing, address wrap, trigger latch
  always_comb begin
    we_d        = 1'b0;
    addr_d      = addr_q;
    wptr_d      = wptr_q;
    trig_addr_d = trig_addr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    done_d      = (state_q == ST_DONE) && (state_d == ST_DONE);
    if (ctrl_rst_c || ctrl_start_c) begin
      addr_d      = '0;
      wptr_d      = '0;
      trig_addr_d = '0;
      cnt_d       = '0;
      prev_d      = '0;
    end else if (tick_ok_c) begin
      we_d   = 1'b1;
      addr_d = wptr_q;
      wptr_d = (wptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wptr_q + ADDR_W'(1);
      prev_d = bus.i_adc1A;
      if (state_d != state_q)              cnt_d = '0;
      else if (cnt_q != CNT_W'(CNT_MAX))   cnt_d = cnt_q + CNT_W'(1);
      if ((state_q == ST_ARMED) && trig_c) trig_addr_d = wptr_q;
    end
    status_d = status_byte(done_d, state_d);
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wptr_q      <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      done_q      <= 1'b0;
      status_q    <= '0;
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      wptr_q      <= wptr_d;
      trig_addr_q <= trig_addr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      done_q      <= done_d;
      status_q    <= status_d;
    end
  end

  assign bus.o_we        = we_q;
  assign bus.o_addr      = addr_q;
  assign bus.o_trig_addr = trig_addr_q;
  assign bus.o_done      = done_q;
  assign bus.o_status    = status_q;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Bench for acquisition_sequencer: per-cycle model comparison plus pinned scenarios.
module tb_acquisition_sequencer;
  import acq_pkg::*;

  localparam int unsigned DEPTH  = 1500;
  localparam int unsigned PRE    = 750;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned AUTO   = 100;
  localparam int unsigned POSTN  = DEPTH - PRE - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  // Reference model: capture phase number, counts and expected outputs
  int              m_phase, m_n, m_wptr, m_prev;
  logic [31:0]     m_div;
  logic            e_we, e_done;
  logic [ADDR_W-1:0] e_addr, e_trig;
  logic [7:0]      e_status;

  // Scenario scratch
  int n, nwe, last, errs, wraps, prev_addr, first_we, last_we, done_at, adc;

  always #5 clk = ~clk;

  acquisition_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  acquisition_sequencer #(
    .DEPTH(DEPTH), .PRE_SAMPLES(PRE), .ADDR_W(ADDR_W), .AUTO_TICKS(AUTO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic model_clear();
    m_div  = '0;
    m_wptr = 0;
    m_n    = 0;
    m_prev = 0;
    e_addr = '0;
    e_trig = '0;
  endtask

  task automatic model_reset();
    m_phase  = 0;
    model_clear();
    e_we     = 1'b0;
    e_done   = 1'b0;
    e_status = 8'h00;
  endtask

  // Advance the model by one rising edge using the inputs presented to it
  task automatic model_step();
    int  old_phase, lvl, cur;
    bit  running, tick, trig;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_phase = m_phase;
    lvl       = int'(bus.i_trig_level);
    cur       = int'(bus.i_adc1A);
    running   = (m_phase >= 1) && (m_phase <= 3);
    tick      = running && (m_div == bus.i_timebase);
    m_div     = (running && !tick) ? m_div + 32'd1 : 32'd0;
    e_we      = 1'b0;
    if (bus.i_ctrl_wr && bus.i_ctrl_data[0]) begin
      m_phase = 0;
      model_clear();
    end else if (bus.i_ctrl_wr) begin
      if (m_phase == 0 || m_phase == 4) begin
        m_phase = 1;
        model_clear();
      end
    end else if (tick) begin
      e_we   = 1'b1;
      e_addr = ADDR_W'(m_wptr);
      m_wptr = (m_wptr + 1) % DEPTH;
      if (m_phase == 1) begin
        m_n++;
        if (m_n == PRE) begin m_phase = 2; m_n = 0; end
      end else if (m_phase == 2) begin
        trig = !bus.i_trig_enable ||
               (!bus.i_trig_mode && m_n == AUTO - 1) ||
               (m_n > 0 && (bus.i_trig_edge ? (m_prev > lvl && cur <= lvl)
                                            : (m_prev < lvl && cur >= lvl)));
        m_n++;
        if (trig) begin
          e_trig  = e_addr;
          m_phase = (POSTN == 0) ? 4 : 3;
          m_n     = 0;
        end
      end else begin
        m_n++;
        if (m_n == POSTN) m_phase = 4;
      end
      m_prev = cur;
    end
    e_done   = (old_phase == 4) && (m_phase == 4);
    e_status = {e_done, 4'b0000, 3'(m_phase)};
  endtask

  task automatic cmp_model();
    logic [31:0] act, exp;
    act = {bus.o_we, bus.o_addr, bus.o_trig_addr, bus.o_done, bus.o_status};
    exp = {e_we, e_addr, e_trig, e_done, e_status};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL model_cmp cyc=%0d: got we=%b addr=%0d trig=%0d done=%b status=%h, expected we=%b addr=%0d trig=%0d done=%b status=%h",
               cyc, bus.o_we, bus.o_addr, bus.o_trig_addr, bus.o_done, bus.o_status,
               e_we, e_addr, e_trig, e_done, e_status);
    end
  endtask

  task automatic chk_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
    cyc++;
  endtask

  task automatic ctrl(input bit rst_bit);
    bus.i_ctrl_wr   = 1'b1;
    bus.i_ctrl_data = {7'd0, rst_bit};
    cycle();
    bus.i_ctrl_wr   = 1'b0;
    bus.i_ctrl_data = 8'h00;
  endtask

  task automatic set_cfg(input int tb, input bit edge_fall, input int lvl, input bit mode, input bit en);
    bus.i_timebase    = 32'(tb);
    bus.i_trig_edge   = edge_fall;
    bus.i_trig_level  = 8'(lvl);
    bus.i_trig_mode   = mode;
    bus.i_trig_enable = en;
  endtask

  function automatic int tri_wave(input int j);
    int p;
    p = j % 100;
    return (p < 50) ? p : 99 - p;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_ctrl_wr   = 1'b0;
    bus.i_ctrl_data = 8'h00;
    bus.i_adc1A     = 8'h00;
    set_cfg(0, 1'b0, 0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    chk_lit("reset_we", 32'(bus.o_we), 0);
    chk_lit("reset_addr", 32'(bus.o_addr), 0);
    chk_lit("reset_trig", 32'(bus.o_trig_addr), 0);
    chk_lit("reset_done", 32'(bus.o_done), 0);
    chk_lit("reset_status", 32'(bus.o_status), 32'h00);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Back-to-back capture, forced trigger on the first ARMED tick
    set_cfg(0, 1'b0, 0, 1'b1, 1'b0);
    ctrl(1'b0);
    n = 0; nwe = 0; errs = 0; first_we = -1; last_we = -1; done_at = -1;
    while (n < 3000 && !bus.o_done) begin
      cycle(); n++;
      if (bus.o_we) begin
        if (int'(bus.o_addr) != nwe) errs++;
        if (first_we < 0) first_we = n;
        last_we = n;
        nwe++;
      end
      if (bus.o_done) done_at = n;
    end
    chk_lit("t1_done", 32'(bus.o_done), 1);
    chk_lit("t1_writes", 32'(nwe), 1500);
    chk_lit("t1_addr_seq_errs", 32'(errs), 0);
    chk_lit("t1_consecutive", 32'(last_we - first_we), 1499);
    chk_lit("t1_trig_addr", 32'(bus.o_trig_addr), 750);
    chk_lit("t1_done_latency", 32'(done_at - last_we), 1);
    chk_lit("t1_hold_addr", 32'(bus.o_addr), 1499);
    chk_lit("t1_status", 32'(bus.o_status), 32'h84);

    // Timebase 3: four clocks per write, 6000 clocks overall
    set_cfg(3, 1'b0, 0, 1'b1, 1'b0);
    ctrl(1'b0);
    n = 0; nwe = 0; errs = 0; last = -1;
    while (n < 7000 && !bus.o_done) begin
      cycle(); n++;
      if (bus.o_we) begin
        if (last >= 0 && n - last != 4) errs++;
        last = n;
        nwe++;
      end
    end
    chk_lit("t2_gap_errs", 32'(errs), 0);
    chk_lit("t2_writes", 32'(nwe), 1500);
    chk_lit("t2_total_clocks_ok", 32'(n >= 5999 && n <= 6001), 1);

    // Rising trigger at level 25 on a triangle wave
    set_cfg(0, 1'b0, 25, 1'b1, 1'b1);
    ctrl(1'b0);
    for (int j = 1; j < 3000 && !bus.o_done; j++) begin
      bus.i_adc1A = 8'(tri_wave(j));
      cycle();
    end
    chk_lit("t3_done", 32'(bus.o_done), 1);
    chk_lit("t3_trig_addr", 32'(bus.o_trig_addr), 824);

    // Falling trigger at level 200 on a sawtooth going down
    set_cfg(0, 1'b1, 200, 1'b1, 1'b1);
    ctrl(1'b0);
    for (int j = 1; j < 3000 && !bus.o_done; j++) begin
      bus.i_adc1A = 8'(250 - (j % 60));
      cycle();
    end
    chk_lit("t3b_done", 32'(bus.o_done), 1);
    chk_lit("t3b_trig_addr", 32'(bus.o_trig_addr), 769);

    // Normal mode, no crossing: stays ARMED and wraps the buffer
    set_cfg(0, 1'b0, 25, 1'b1, 1'b1);
    bus.i_adc1A = 8'd10;
    ctrl(1'b0);
    wraps = 0; prev_addr = -1;
    repeat (3700) begin
      cycle();
      if (bus.o_we) begin
        if (prev_addr == 1499 && bus.o_addr == '0) wraps++;
        prev_addr = int'(bus.o_addr);
      end
    end
    chk_lit("t4_wraps", 32'(wraps), 2);
    chk_lit("t4_done", 32'(bus.o_done), 0);
    chk_lit("t4_armed", 32'(bus.o_status), 32'h02);
    ctrl(1'b0);
    cycle();
    chk_lit("t4_run_ignored", 32'(bus.o_status), 32'h02);
    ctrl(1'b1);
    chk_lit("t4_idle", 32'(bus.o_status), 32'h00);

    // Auto mode forces the trigger on the 100th ARMED tick
    set_cfg(0, 1'b0, 25, 1'b0, 1'b1);
    bus.i_adc1A = 8'd10;
    ctrl(1'b0);
    n = 0;
    while (n < 3000 && !bus.o_done) begin cycle(); n++; end
    chk_lit("t5_done", 32'(bus.o_done), 1);
    chk_lit("t5_trig_addr", 32'(bus.o_trig_addr), 849);

    // Reset write in the middle of POST, colliding with a tick
    set_cfg(0, 1'b0, 0, 1'b1, 1'b0);
    ctrl(1'b0);
    repeat (851) cycle();
    chk_lit("t6_in_post", 32'(bus.o_status), 32'h03);
    ctrl(1'b1);
    chk_lit("t6_status", 32'(bus.o_status), 32'h00);
    chk_lit("t6_no_we", 32'(bus.o_we), 0);
    chk_lit("t6_addr", 32'(bus.o_addr), 0);
    chk_lit("t6_trig", 32'(bus.o_trig_addr), 0);
    cycle();

    // Asynchronous reset in the middle of PREFILL
    ctrl(1'b0);
    repeat (200) cycle();
    chk_lit("t7_in_prefill", 32'(bus.o_status), 32'h01);
    rst_n = 1'b0;
    #1;
    chk_lit("t7_we", 32'(bus.o_we), 0);
    chk_lit("t7_addr", 32'(bus.o_addr), 0);
    chk_lit("t7_status", 32'(bus.o_status), 32'h00);
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Randomized captures against the model
    for (int r = 0; r < 5; r++) begin
      ctrl(1'b1);
      set_cfg(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), int'($urandom_range(20, 230)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
      adc = int'($urandom_range(0, 255));
      ctrl(1'b0);
      for (int k = 0; k < 6000 && !bus.o_done && bus.o_status[2:0] != 3'd0; k++) begin
        adc = adc + int'($urandom_range(0, 40)) - 20;
        if (adc < 0)   adc = 0;
        if (adc > 255) adc = 255;
        bus.i_adc1A = 8'(adc);
        if ($urandom_range(0, 499) == 0) begin
          bus.i_ctrl_wr   = 1'b1;
          bus.i_ctrl_data = {7'd0, ($urandom_range(0, 3) == 0)};
        end
        cycle();
        bus.i_ctrl_wr   = 1'b0;
        bus.i_ctrl_data = 8'h00;
      end
      repeat (3) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/acquisition_sequencer.md
# acquisition_sequencer

Sequences one ADC capture for the 1013D sampling path. It takes the capture configuration written by the MCU command decoder: time base (cmd 0x0E), trigger edge (0x16), trigger level (0x17), trigger mode (0x1A), trigger enable (0x0F), and sampling control (0x01). From these it paces sample writes into the capture RAM, fills the pre-trigger window, detects the trigger on channel 1A, finishes the post-trigger window, and raises done for the status read (0x0A). It sits between the command decoder and the sample RAM write port, in the ADC clock domain.

## Interface
Parameters:
- DEPTH, 1500, total samples per capture (capture RAM length).
- PRE_SAMPLES, 750, pre-trigger samples; must satisfy 1 ≤ PRE_SAMPLES < DEPTH.
- ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W ≥ DEPTH.
- AUTO_TICKS, 65535, sample ticks in ARMED before auto mode forces a trigger.

Ports:
- i_clk, in, 1, sample clock; one clock; all logic on its rising edge.
- i_rst_n, in, 1, asynchronous, active-low reset.
- i_timebase, in, 32, sample divider; one tick every i_timebase+1 clocks.
- i_trig_edge, in, 1, 0 = rising, 1 = falling.
- i_trig_level, in, 8, trigger threshold.
- i_trig_mode, in, 1, 0 = auto, 1 = normal.
- i_trig_enable, in, 1, 0 = trigger immediately on entering ARMED.
- i_ctrl_wr, in, 1, one-clock strobe meaning the sampling-control byte was written.
- i_ctrl_data, in, 8, sampling-control byte; bit0 = 1 means reset stage, bit0 = 0 means run stage.
- i_adc1A, in, 8, channel 1A sample used for triggering.
- o_we, out, 1, RAM write enable, one clock per tick.
- o_addr, out, ADDR_W, RAM write address.
- o_trig_addr, out, ADDR_W, address of the trigger sample.
- o_done, out, 1, capture complete.
- o_status, out, 8, {o_done, 4'b0, state[2:0]}.

## Operation
- Sampling is paced by a divider counter that runs only outside IDLE and DONE. The tick fires when the counter equals i_timebase, and the counter then clears. i_timebase = 0 means a tick every clock. A changed i_timebase takes effect at the next counter compare.
- The state machine has five states: IDLE=0, PREFILL=1, ARMED=2, POST=3, DONE=4.
- IDLE: no writes. In this state the address, the counters, o_done and o_trig_addr are all 0.
- Any i_ctrl_wr with bit0 = 1 sends the block to IDLE from any state, in the next clock.
- i_ctrl_wr with bit0 = 0:
  - in IDLE or DONE, it starts a capture: go to PREFILL, with address, counters and o_done cleared.
  - in any other state, it is ignored.
- PREFILL: write on each tick. After PRE_SAMPLES writes, go to ARMED.
- ARMED: keep writing on each tick; the buffer is circular. The block holds prev, the last ticked sample.
  - Rising trigger: prev < level and cur ≥ level.
  - Falling trigger: prev > level and cur ≤ level.
  - Forced trigger: i_trig_enable = 0, or auto mode with AUTO_TICKS ticks elapsed in ARMED.
  - On a trigger tick, the sample is written, o_trig_addr latches that write's address, and the state goes to POST.
  - Normal mode with no edge stays in ARMED indefinitely.
- POST: write exactly DEPTH−PRE_SAMPLES−1 further samples, then go to DONE.
- DONE: o_done = 1, no writes. o_addr holds the last written address.
- Address rule: the address increments after every write and wraps from DEPTH−1 to 0. There is no full or overflow flag; overwrite in ARMED is intended.
- Arithmetic: prev and cur compare unsigned 8-bit. prev is reset to 0 on entering PREFILL, and prev is not compared on the first ARMED tick.

## Timing
- Reset values: o_we = 0, o_addr = 0, o_trig_addr = 0, o_done = 0, o_status = 0x00, state IDLE.
- Write latency: o_we and o_addr are registered. They assert the clock after the tick, which samples i_adc1A at the tick.
- The trigger decision uses the same registered sample. The state moves to POST in the same clock that o_we for the trigger sample is high.
- o_done rises the clock after the final POST write.
- A control write and a tick in the same clock: the control write wins, and the tick is discarded.
- Reset mid-operation, via i_rst_n or ctrl bit0 = 1: any pending write is dropped and no partial state is kept.
- Configuration inputs are sampled live. The MCU changes them only while the block is in IDLE; behaviour during a capture is defined only for i_timebase.

## Structure
- A shared package acq_pkg holds:
  - the state encoding constants, which are also used by the status-read mux;
  - the control-bit index (CTRL_RESET_BIT = 0);
  - the mode and edge constants.
- Natural sub-module: sample_tick_gen, the 32-bit divider with enable, producing the tick.
- The trigger comparator and the state machine stay in acquisition_sequencer.

## Test plan
- Reset, then ctrl=0 with timebase 0, trig_enable 0: 1500 consecutive o_we pulses at addresses 0…1499, o_trig_addr = 750, and o_done rises one clock after the final write.
- Timebase 3: o_we spacing is exactly 4 clocks, and the total capture takes 6000 clocks ±1.
- Rising edge, level 25, normal mode, triangle ramp on 1A: trigger fires on the first ARMED tick with sample ≥ 25 after a sample < 25; o_trig_addr equals that write's address.
- Normal mode with no crossing (1A held at 10): the block stays in ARMED and the address wraps 1499→0 repeatedly; o_done stays 0. Auto mode with AUTO_TICKS = 100: a forced trigger occurs at the 100th ARMED tick.
- Falling edge, level 200, with a downward ramp: trigger fires on a sample ≤ 200 after a sample > 200.
- Boundary events:
  - ctrl=1 in mid-POST: the next clock shows IDLE with o_status = 0x00.
  - ctrl=0 issued during ARMED: ignored.
  - ctrl write in the same clock as a tick: no o_we is generated.
  - i_rst_n asserted mid-PREFILL: all outputs return to 0 asynchronously.
